dcache_dirty_flush_ctrl: RTL and testbench
==========================================

Name: dcache_dirty_flush_ctrl

Overview:
- Flush sequencer and access arbiter in front of the D-cache dirty-bit table.
- In normal operation it passes the pipeline's dirty set/clear requests straight through.
- On a flush command it takes ownership of the table and walks every (set, way). Each dirty line gets a writeback request to the memory side; after the acknowledge it clears that dirty bit.
- Sits between the Dcache main FSM, the dirty table, and the writeback path.

Parameters:
- addr_width, 4: set-index width; the table has 2^addr_width sets.
- way, 2: associativity. Way index width WW = max(1, $clog2(way)).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush_req  input  1  flush command; sampled only in IDLE.
- flush_busy  output  1  high while the flush walk is in progress (SCAN/WB/CLEAR/DONE).
- flush_done  output  1  one-cycle pulse when the walk completes.
- pipe_addr  input  addr_width  pipeline dirty-table set index.
- pipe_way  input  WW  pipeline way select.
- pipe_set1  input  1  pipeline request to mark the line dirty.
- pipe_set0  input  1  pipeline request to mark the line clean.
- pipe_stall  output  1  equals flush_busy; pipeline requests are dropped while high.
- dt_addr  output  addr_width  dirty-table set index.
- dt_way_select  output  WW  dirty-table way.
- dt_set1  output  1  dirty-table set strobe.
- dt_set0  output  1  dirty-table clear strobe.
- dt_dirty  input  1  dirty-table combinational read of (dt_addr, dt_way_select).
- wb_req  output  1  writeback request.
- wb_addr  output  addr_width  set of the line to write back.
- wb_way  output  WW  way of the line to write back.
- wb_ack  input  1  writeback accepted/complete.

Behaviour:
- States: IDLE, SCAN, WB, CLEAR, DONE. Reset: state=IDLE, counters=0, and every registered output is 0 (flush_busy, flush_done, wb_req, wb_addr, wb_way).
- IDLE:
  - dt_addr/dt_way_select/dt_set1/dt_set0 are driven combinationally from the pipe_* inputs.
  - If pipe_set1 and pipe_set0 are both high, only dt_set1 is asserted (set1 wins).
  - flush_req=1 moves to SCAN next cycle with set_cnt=0, way_cnt=0. A pipeline op in the same cycle is still performed.
- SCAN, WB, CLEAR:
  - dt_addr=set_cnt and dt_way_select=way_cnt.
  - pipe_set1/pipe_set0 are ignored; they are never forwarded.
- SCAN:
  - dt_dirty=1: capture wb_addr/wb_way from the counters, go to WB, and assert wb_req from the next cycle.
  - dt_dirty=0: advance the counters. If this was the last entry, go to DONE; otherwise stay in SCAN.
  - Cost: one cycle per clean entry.
- WB:
  - wb_req, wb_addr and wb_way are held stable until wb_ack=1 is sampled.
  - On that edge: wb_req=0, go to CLEAR.
  - wb_ack is ignored outside WB. No timeout.
- CLEAR:
  - dt_set0=1 for exactly one cycle at (set_cnt, way_cnt).
  - Advance the counters. If this was the last entry, go to DONE; otherwise go to SCAN.
- Counter order:
  - way_cnt is the inner loop and set_cnt the outer: (0,0),(0,1),(1,0),…
  - "Last entry" = set_cnt = 2^addr_width-1 and way_cnt = way-1. Advancing from the last entry wraps both counters to 0.
- DONE: flush_done=1 for one cycle (flush_busy is still 1), then IDLE. flush_busy drops in the same cycle flush_done drops.
- flush_req while busy is ignored; it is not queued.
- rst asserted mid-flush:
  - Next cycle: IDLE, with wb_req dropped even without an ack.
  - No dirty bit is cleared by the aborted walk.
- Latency with all lines clean: flush_req edge to flush_done pulse = 2 + 2^addr_width·way cycles. With defaults: 34.

Optional Feature:
- Macro: DCACHE_FLUSH_STAT_EN.
- Defined:
  - Adds output flush_wb_cnt, width addr_width+WW+1.
  - It clears to 0 on the IDLE→SCAN transition and increments on each accepted wb_ack.
  - It holds its value after DONE until the next flush; it is 0 on reset.
- Not defined: the port and the counter are absent; behaviour is otherwise identical.

Test Plan:
- All clean, defaults. flush_req pulse at cycle 0 → flush_busy=1 from cycle 1, wb_req never asserted, flush_done pulse at cycle 34, pipe_stall=0 at cycle 35.
- Dirty at (3,1) only, wb_ack 4 cycles after wb_req → wb_req=1 with wb_addr=3, wb_way=1 held 4 cycles; then dt_set0=1 at addr 3 way 1 for one cycle; flush_done once. flush_wb_cnt=1 if DCACHE_FLUSH_STAT_EN.
- Dirty at (0,0) and (15,1) → exactly two writebacks in that order, walk wraps the counters to 0, table all clean afterwards. flush_wb_cnt=2 if enabled.
- pipe_set1 at addr 5 way 0 in the same cycle as flush_req → the set is applied, and line (5,0) is then written back during the walk. pipe_set1 issued mid-flush → dt_set1 stays 0 and pipe_stall=1.
- rst pulsed while wb_req=1 → next cycle IDLE, wb_req=0, flush_busy=0, the dirty bit is still 1. flush_req afterwards → the walk restarts at (0,0).
- flush_req pulsed again mid-walk → ignored, only one flush_done pulse. wb_ack pulsed while in IDLE → no effect.

Source files
------------

// File: rtl/dcache_dirty_flush_ctrl.sv
// dcache_dirty_flush_ctrl
//   Arbiter and flush sequencer for the D-cache dirty-bit table. In IDLE the
//   pipeline's set/clear requests pass straight through. On a flush command the
//   block owns the table, walks every (set, way) with way as the inner loop,
//   issues a writeback for each dirty line and clears its bit once acknowledged.
//   Optional build macro: DCACHE_FLUSH_STAT_EN adds the flush_wb_cnt output,
//   the number of writebacks accepted during the most recent flush.
module dcache_dirty_flush_ctrl #(
    parameter  int addr_width = 4,
    parameter  int way        = 2,
    localparam int WW         = (way > 1) ? $clog2(way) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_req,
    output logic                  flush_busy,
    output logic                  flush_done,
    input  logic [addr_width-1:0] pipe_addr,
    input  logic [WW-1:0]         pipe_way,
    input  logic                  pipe_set1,
    input  logic                  pipe_set0,
    output logic                  pipe_stall,
    output logic [addr_width-1:0] dt_addr,
    output logic [WW-1:0]         dt_way_select,
    output logic                  dt_set1,
    output logic                  dt_set0,
    input  logic                  dt_dirty,
    output logic                  wb_req,
    output logic [addr_width-1:0] wb_addr,
    output logic [WW-1:0]         wb_way,
    input  logic                  wb_ack
`ifdef DCACHE_FLUSH_STAT_EN
    ,
    output logic [addr_width+WW:0] flush_wb_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_WB,
        S_CLEAR,
        S_DONE
    } state_t;

    localparam logic [addr_width-1:0] LAST_SET = '1;
    localparam logic [WW-1:0]         LAST_WAY = WW'(way - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [addr_width-1:0] r_set_cnt;
    logic [addr_width-1:0] w_set_next;
    logic [WW-1:0]         r_way_cnt;
    logic [WW-1:0]         w_way_next;
    logic                  r_flush_busy;
    logic                  r_flush_done;
    logic                  r_wb_req;
    logic [addr_width-1:0] r_wb_addr;
    logic [WW-1:0]         r_wb_way;

    logic                  w_last;
    logic                  w_way_wrap;
    logic [addr_width-1:0] w_set_adv;
    logic [WW-1:0]         w_way_adv;
    logic                  w_flush_start;

    // Walk position helpers: way is the inner loop, both counters wrap after the last entry.
    assign w_way_wrap = (r_way_cnt == LAST_WAY);
    assign w_last     = w_way_wrap && (r_set_cnt == LAST_SET);
    assign w_way_adv  = w_way_wrap ? '0 : r_way_cnt + 1'b1;
    assign w_set_adv  = w_way_wrap ? r_set_cnt + 1'b1 : r_set_cnt;

    // The busy flag also covers the flush_done pulse cycle, so IDLE only
    // accepts new work once busy has dropped.
    assign w_flush_start = (r_state == S_IDLE) && !r_flush_busy && flush_req;

    // Next-state, counter update and dirty-table port mux.
    always_comb begin
        w_state_next  = r_state;
        w_set_next    = r_set_cnt;
        w_way_next    = r_way_cnt;
        dt_addr       = r_set_cnt;
        dt_way_select = r_way_cnt;
        dt_set1       = 1'b0;
        dt_set0       = 1'b0;
        case (r_state)
            S_IDLE: begin
                dt_addr       = pipe_addr;
                dt_way_select = pipe_way;
                if (!r_flush_busy) begin
                    dt_set1 = pipe_set1;
                    dt_set0 = pipe_set0 && !pipe_set1;
                end
                if (w_flush_start) begin
                    w_state_next = S_SCAN;
                    w_set_next   = '0;
                    w_way_next   = '0;
                end
            end
            S_SCAN: begin
                if (dt_dirty) begin
                    w_state_next = S_WB;
                end else begin
                    w_set_next   = w_set_adv;
                    w_way_next   = w_way_adv;
                    w_state_next = w_last ? S_DONE : S_SCAN;
                end
            end
            S_WB: begin
                if (wb_ack) begin
                    w_state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                dt_set0      = 1'b1;
                w_set_next   = w_set_adv;
                w_way_next   = w_way_adv;
                w_state_next = w_last ? S_DONE : S_SCAN;
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, walk counters and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_set_cnt    <= '0;
            r_way_cnt    <= '0;
            r_flush_busy <= 1'b0;
            r_flush_done <= 1'b0;
            r_wb_req     <= 1'b0;
            r_wb_addr    <= '0;
            r_wb_way     <= '0;
        end else begin
            r_state      <= w_state_next;
            r_set_cnt    <= w_set_next;
            r_way_cnt    <= w_way_next;
            r_flush_done <= (r_state == S_DONE);
            if (w_flush_start) begin
                r_flush_busy <= 1'b1;
            end else if (r_flush_done) begin
                r_flush_busy <= 1'b0;
            end
            if (r_state == S_SCAN && dt_dirty) begin
                r_wb_req  <= 1'b1;
                r_wb_addr <= r_set_cnt;
                r_wb_way  <= r_way_cnt;
            end else if (r_state == S_WB && wb_ack) begin
                r_wb_req <= 1'b0;
            end
        end
    end

`ifdef DCACHE_FLUSH_STAT_EN
    logic [addr_width+WW:0] r_flush_wb_cnt;

    // Writeback counter for the current/most recent flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_wb_cnt <= '0;
        end else if (w_flush_start) begin
            r_flush_wb_cnt <= '0;
        end else if (r_state == S_WB && wb_ack) begin
            r_flush_wb_cnt <= r_flush_wb_cnt + 1'b1;
        end
    end

    assign flush_wb_cnt = r_flush_wb_cnt;
`endif

    assign flush_busy = r_flush_busy;
    assign flush_done = r_flush_done;
    assign pipe_stall = r_flush_busy;
    assign wb_req     = r_wb_req;
    assign wb_addr    = r_wb_addr;
    assign wb_way     = r_wb_way;

endmodule

// File: tb/tb_dcache_dirty_flush_ctrl.sv
// tb_dcache_dirty_flush_ctrl
//   Bench for the dirty-table flush controller with default parameters
//   (16 sets, 2 ways). The bench holds the dirty table itself and a separate
//   reference view of which lines should be dirty; each flush is predicted as
//   an ordered list of writebacks and a total cycle count.
module tb_dcache_dirty_flush_ctrl;

    localparam int SETS = 16;
    localparam int WAYS = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush_req;
    logic       flush_busy;
    logic       flush_done;
    logic [3:0] pipe_addr;
    logic       pipe_way;
    logic       pipe_set1;
    logic       pipe_set0;
    logic       pipe_stall;
    logic [3:0] dt_addr;
    logic       dt_way_select;
    logic       dt_set1;
    logic       dt_set0;
    logic       dt_dirty;
    logic       wb_req;
    logic [3:0] wb_addr;
    logic       wb_way;
    logic       wb_ack;
`ifdef DCACHE_FLUSH_STAT_EN
    logic [5:0] flush_wb_cnt;
`endif

    int nassert = 0;
    int nfail   = 0;

    dcache_dirty_flush_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .flush_req     (flush_req),
        .flush_busy    (flush_busy),
        .flush_done    (flush_done),
        .pipe_addr     (pipe_addr),
        .pipe_way      (pipe_way),
        .pipe_set1     (pipe_set1),
        .pipe_set0     (pipe_set0),
        .pipe_stall    (pipe_stall),
        .dt_addr       (dt_addr),
        .dt_way_select (dt_way_select),
        .dt_set1       (dt_set1),
        .dt_set0       (dt_set0),
        .dt_dirty      (dt_dirty),
        .wb_req        (wb_req),
        .wb_addr       (wb_addr),
        .wb_way        (wb_way),
        .wb_ack        (wb_ack)
`ifdef DCACHE_FLUSH_STAT_EN
        ,
        .flush_wb_cnt  (flush_wb_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Physical dirty table driven by the DUT's strobes.
    logic tbl [0:SETS-1][0:WAYS-1] = '{default: 1'b0};
    always @(posedge clk) begin
        if (dt_set1)      tbl[dt_addr][dt_way_select] <= 1'b1;
        else if (dt_set0) tbl[dt_addr][dt_way_select] <= 1'b0;
    end
    assign dt_dirty = tbl[dt_addr][dt_way_select];

    // Reference view: which lines ought to be dirty.
    bit ref_d [0:SETS-1][0:WAYS-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nassert++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_table(input string tag);
        logic [31:0] got_v;
        logic [31:0] exp_v;
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                got_v[s*WAYS+w] = tbl[s][w];
                exp_v[s*WAYS+w] = ref_d[s][w];
            end
        end
        chk(tag, got_v, exp_v);
    endtask

    task automatic quiet();
        @(negedge clk);
        pipe_set1 = 1'b0;
        pipe_set0 = 1'b0;
        flush_req = 1'b0;
        wb_ack    = 1'b0;
    endtask

    // One pipeline request while idle: forwarded at once, set1 beats set0.
    task automatic pipe_op(input bit s1, input bit s0, input int a, input int w);
        @(negedge clk);
        pipe_set1 = s1;
        pipe_set0 = s0;
        pipe_addr = a[3:0];
        pipe_way  = w[0];
        #1;
        chk("idle_dt_set1", dt_set1, s1);
        chk("idle_dt_set0", dt_set0, s0 & ~s1);
        chk("idle_dt_addr", dt_addr, a);
        chk("idle_dt_way", dt_way_select, w);
        if (s1)      ref_d[a][w] = 1'b1;
        else if (s0) ref_d[a][w] = 1'b0;
        $display("pipe op set1=%0d set0=%0d at (%0d,%0d)", s1, s0, a, w);
    endtask

    // Full flush: predicts writeback order and completion cycle, responds to wb_req.
    task automatic run_flush(input bit with_pipe, input int pa, input int pw,
                             input int fixed_d, input bit noise);
        int q_a[$];
        int q_w[$];
        int cur_a, cur_w, held, d, exp_done, nwb, n_exp;
        bit in_req, seen, exp_set0;
        cur_a = -1; cur_w = -1; held = 0; d = 0; nwb = 0; in_req = 0; seen = 0;
        @(negedge clk);
        flush_req = 1'b1;
        wb_ack    = 1'b0;
        pipe_set1 = with_pipe;
        pipe_set0 = 1'b0;
        pipe_addr = pa[3:0];
        pipe_way  = pw[0];
        #1;
        chk("start_busy_low", flush_busy, 1'b0);
        if (with_pipe) begin
            chk("start_dt_set1", dt_set1, 1'b1);
            chk("start_dt_addr", dt_addr, pa);
            ref_d[pa][pw] = 1'b1;
        end
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                if (ref_d[s][w]) begin
                    q_a.push_back(s);
                    q_w.push_back(w);
                end
            end
        end
        n_exp    = q_a.size();
        exp_done = 2 + SETS * WAYS;
        for (int cyc = 1; cyc <= 1000 && !seen; cyc++) begin
            @(negedge clk);
            flush_req = 1'b0;
            pipe_set1 = 1'b0;
            pipe_set0 = 1'b0;
            if (noise) begin
                pipe_set1 = ($urandom_range(0, 2) == 0);
                pipe_set0 = ($urandom_range(0, 2) == 0);
                pipe_addr = 4'($urandom_range(0, SETS - 1));
                pipe_way  = 1'($urandom_range(0, WAYS - 1));
                flush_req = ($urandom_range(0, 5) == 0);
            end
            #1;
            chk("walk_busy", flush_busy, 1'b1);
            chk("walk_stall", pipe_stall, 1'b1);
            chk("walk_no_set1", dt_set1, 1'b0);
            exp_set0 = 1'b0;
            if (wb_req === 1'b1) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    held   = 1;
                    d      = (fixed_d >= 0) ? fixed_d : int'($urandom_range(0, 4));
                    chk("wb_expected", q_a.size() > 0, 1'b1);
                    if (q_a.size() > 0) begin
                        cur_a = q_a.pop_front();
                        cur_w = q_w.pop_front();
                    end
                    nwb++;
                    $display("writeback %0d at (%0d,%0d) ack after %0d", nwb, wb_addr, wb_way, d);
                end else begin
                    held++;
                end
                chk("wb_addr", wb_addr, cur_a);
                chk("wb_way", wb_way, cur_w);
                wb_ack = (held == d + 1);
            end else begin
                wb_ack = 1'b0;
                if (in_req) begin
                    in_req = 1'b0;
                    chk("wb_hold_cycles", held, d + 1);
                    exp_done += d + 2;
                    exp_set0  = 1'b1;
                end
            end
            chk("walk_dt_set0", dt_set0, exp_set0);
            if (exp_set0) begin
                chk("clear_addr", dt_addr, cur_a);
                chk("clear_way", dt_way_select, cur_w);
            end
            if (flush_done === 1'b1) begin
                seen = 1'b1;
                chk("done_cycle", cyc, exp_done);
                chk("wb_all_issued", q_a.size(), 0);
            end
        end
        chk("done_seen", seen, 1'b1);
        chk("wb_count", nwb, n_exp);
        @(negedge clk);
        flush_req = 1'b0;
        pipe_set1 = 1'b0;
        pipe_set0 = 1'b0;
        wb_ack    = 1'b0;
        #1;
        chk("after_done_low", flush_done, 1'b0);
        chk("after_busy_low", flush_busy, 1'b0);
        chk("after_stall_low", pipe_stall, 1'b0);
        chk("after_wb_req_low", wb_req, 1'b0);
`ifdef DCACHE_FLUSH_STAT_EN
        chk("flush_wb_cnt", flush_wb_cnt, nwb);
`endif
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                ref_d[s][w] = 1'b0;
        check_table("table_clean_after_flush");
        $display("flush complete: %0d writebacks, expected done at cycle %0d", nwb, exp_done);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst       = 1'b1;
        flush_req = 1'b0;
        pipe_addr = '0;
        pipe_way  = 1'b0;
        pipe_set1 = 1'b0;
        pipe_set0 = 1'b0;
        wb_ack    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_busy", flush_busy, 1'b0);
        chk("reset_done", flush_done, 1'b0);
        chk("reset_wb_req", wb_req, 1'b0);
        chk("reset_wb_addr", wb_addr, 4'd0);
        chk("reset_wb_way", wb_way, 1'b0);
        chk("reset_stall", pipe_stall, 1'b0);
        $display("reset checked");
        @(negedge clk);
        rst = 1'b0;

        // All lines clean: 34-cycle walk, no writebacks.
        run_flush(1'b0, 0, 0, -1, 1'b0);

        // wb_ack while idle has no effect.
        @(negedge clk);
        wb_ack = 1'b1;
        @(negedge clk);
        wb_ack = 1'b0;
        #1;
        chk("idle_ack_wb_req", wb_req, 1'b0);
        chk("idle_ack_busy", flush_busy, 1'b0);
        $display("idle wb_ack ignored");

        // Random idle pipeline traffic, then a flush with random interference.
        for (int i = 0; i < 24; i++) begin
            pipe_op($urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, SETS - 1), $urandom_range(0, WAYS - 1));
        end
        quiet();
        check_table("table_after_idle_ops");
        run_flush(1'b0, 0, 0, -1, 1'b1);

        // Single dirty line (3,1), ack on the fourth request cycle.
        pipe_op(1'b1, 1'b0, 3, 1);
        quiet();
        run_flush(1'b0, 0, 0, 3, 1'b0);

        // First and last entries dirty: order and counter wrap.
        pipe_op(1'b1, 1'b0, 15, 1);
        pipe_op(1'b1, 1'b0, 0, 0);
        quiet();
        run_flush(1'b0, 0, 0, -1, 1'b0);

        // Pipeline set in the flush_req cycle is applied and written back.
        run_flush(1'b1, 5, 0, -1, 1'b1);

        // Random dirty pattern with random ack delays.
        for (int i = 0; i < 10; i++) begin
            pipe_op(1'b1, 1'b0, $urandom_range(0, SETS - 1), $urandom_range(0, WAYS - 1));
        end
        quiet();
        run_flush(1'b0, 0, 0, -1, 1'b1);

        // Reset while a writeback is outstanding.
        pipe_op(1'b1, 1'b0, 2, 0);
        pipe_op(1'b1, 1'b0, 7, 1);
        quiet();
        @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        k = 0;
        #1;
        while (wb_req !== 1'b1 && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("abort_reached_wb", wb_req, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_wb_req", wb_req, 1'b0);
        chk("abort_busy", flush_busy, 1'b0);
        chk("abort_done", flush_done, 1'b0);
        chk("abort_stall", pipe_stall, 1'b0);
        chk("abort_line_dirty", tbl[2][0], 1'b1);
        check_table("abort_table");
        $display("reset during writeback checked");
        run_flush(1'b0, 0, 0, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
